// File: rtl/sclk_bcd_counter_pkg.sv
// sclk_bcd_counter_pkg: shared state type, BCD constants and per-digit step function
package sclk_bcd_counter_pkg;

    typedef enum logic {STOPPED, RUNNING} state_t;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    function automatic logic [BCD_W:0] bcd_step(input logic [BCD_W-1:0] d, input logic up, input logic cin);
        if (!cin) return {1'b0, d};
        if (up) return (d >= BCD_MAX) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
        return (d == 4'd0) ? {1'b1, BCD_MAX} : {1'b0, d - 4'd1};
    endfunction

endpackage

// File: rtl/sclk_bcd_counter_edge_sync.sv
// sclk_edge_sync: synchronises sclk into clk, detects edges, masks the post-reset prime window
module sclk_edge_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_SEL    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    output logic sedge
);

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES:0]   prime;
    logic                   h;
    logic                   s;

    assign s     = sync[SYNC_STAGES-1];
    assign sedge = prime[SYNC_STAGES] & (EDGE_SEL ? (s ^ h) : (s & ~h));

    // synchroniser chain, history flop and prime shift register filling with ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= '0;
            h     <= 1'b0;
            prime <= '0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], sclk};
            h     <= s;
            prime <= {prime[SYNC_STAGES-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/sclk_bcd_counter.sv
// sclk_bcd_counter: start/stop gated packed-BCD up/down counter advanced by sclk edges
module sclk_bcd_counter
    import sclk_bcd_counter_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_SEL    = 1'b0,
    parameter bit AUTOSTOP    = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sclk,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    up_dn,
    input  logic                    clear,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    tick,
    output logic                    wrap,
    output logic                    load_err,
    output logic                    running
);

    state_t                  state, state_n;
    logic                    sedge;
    logic                    cnt_en;
    logic                    do_wrap;
    logic [DIGITS:0]         c;
    logic [DIGITS-1:0]       bad;
    logic [BCD_W*DIGITS-1:0] cnt;
    logic [BCD_W*DIGITS-1:0] ld;

    sclk_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_SEL    (EDGE_SEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .sclk  (sclk),
        .sedge (sedge)
    );

    assign c[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_dig
            assign {c[i+1], cnt[BCD_W*i +: BCD_W]} = bcd_step(bcd[BCD_W*i +: BCD_W], up_dn, c[i]);
            assign bad[i] = load_val[BCD_W*i +: BCD_W] > BCD_MAX;
            assign ld[BCD_W*i +: BCD_W] = bad[i] ? BCD_MAX : load_val[BCD_W*i +: BCD_W];
        end
    endgenerate

    assign running = state == RUNNING;
    assign cnt_en  = sedge & running;
    assign do_wrap = !clear && !load && cnt_en && c[DIGITS];

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= STOPPED;
        else        state <= state_n;
    end

    // next state: stop and autostop wrap dominate start
    always_comb begin
        state_n = state;
        state_n = (stop || (AUTOSTOP && do_wrap)) ? STOPPED : start ? RUNNING : state;
    end

    // counter and registered pulse outputs, clear over load over count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd      <= '0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tick     <= sedge;
            wrap     <= do_wrap;
            load_err <= !clear && load && |bad;
            bcd      <= clear ? '0 : load ? ld : cnt_en ? cnt : bcd;
        end
    end

endmodule

// File: tb/tb_sclk_bcd_counter.sv
// tb_sclk_bcd_counter: directed checks of sync latency, BCD wrap, load/clear priority and state control
module tb_sclk_bcd_counter;

    logic        clk = 1'b0, reset = 1'b0, sclk = 1'b0;
    logic        start = 1'b0, stop = 1'b0, up_dn = 1'b1, clear = 1'b0, load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] bcd, bcd_a, bcd_e;
    logic        tick, wrap, load_err, running;
    logic        tick_a, wrap_a, load_err_a, running_a;
    logic        tick_e, wrap_e, load_err_e, running_e;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    sclk_bcd_counter #(.DIGITS(4), .SYNC_STAGES(2), .EDGE_SEL(1'b0), .AUTOSTOP(1'b0)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .start(start), .stop(stop), .up_dn(up_dn),
        .clear(clear), .load(load), .load_val(load_val), .bcd(bcd), .tick(tick), .wrap(wrap),
        .load_err(load_err), .running(running));

    sclk_bcd_counter #(.DIGITS(4), .SYNC_STAGES(2), .EDGE_SEL(1'b0), .AUTOSTOP(1'b1)) dut_a (
        .clk(clk), .reset(reset), .sclk(sclk), .start(start), .stop(stop), .up_dn(up_dn),
        .clear(clear), .load(load), .load_val(load_val), .bcd(bcd_a), .tick(tick_a), .wrap(wrap_a),
        .load_err(load_err_a), .running(running_a));

    sclk_bcd_counter #(.DIGITS(4), .SYNC_STAGES(2), .EDGE_SEL(1'b1), .AUTOSTOP(1'b0)) dut_e (
        .clk(clk), .reset(reset), .sclk(sclk), .start(start), .stop(stop), .up_dn(up_dn),
        .clear(clear), .load(load), .load_val(load_val), .bcd(bcd_e), .tick(tick_e), .wrap(wrap_e),
        .load_err(load_err_e), .running(running_e));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rise3();
        sclk = 1'b1;
        step(3);
    endtask

    task automatic tail(input int used);
        step(10 - used);
        sclk = 1'b0;
        step(10);
    endtask

    initial begin
        step(2);
        chk("rst_bcd", bcd, 16'h0000);
        chk("rst_run", running, 1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_lerr", load_err, 1'b0);
        reset = 1'b1;
        step(3);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("s1_run", running, 1'b1);
        for (int k = 0; k < 12; k++) begin
            sclk = 1'b1;
            step(2);
            chk("s1_tick_early", tick, 1'b0);
            step();
            chk("s1_tick", tick, 1'b1);
            chk("s1_wrap", wrap, 1'b0);
            step();
            chk("s1_tick_one", tick, 1'b0);
            tail(4);
        end
        chk("s1_bcd", bcd, 16'h0012);

        load_val = 16'h9998;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("s2_load", bcd, 16'h9998);
        chk("s2_lerr", load_err, 1'b0);
        up_dn = 1'b1;
        rise3();
        chk("s2_bcd1", bcd, 16'h9999);
        chk("s2_wrap1", wrap, 1'b0);
        tail(3);
        rise3();
        chk("s2_bcd2", bcd, 16'h0000);
        chk("s2_wrap2", wrap, 1'b1);
        chk("s2_run", running, 1'b1);
        chk("s2_bcd_a", bcd_a, 16'h0000);
        chk("s2_wrap_a", wrap_a, 1'b1);
        chk("s2_run_a", running_a, 1'b0);
        step();
        chk("s2_wrap_drop", wrap, 1'b0);
        tail(4);

        load_val = 16'h0100;
        load = 1'b1;
        up_dn = 1'b0;
        step();
        load = 1'b0;
        rise3();
        chk("s3_bcd1", bcd, 16'h0099);
        chk("s3_wrap1", wrap, 1'b0);
        tail(3);
        load_val = 16'h0000;
        load = 1'b1;
        step();
        load = 1'b0;
        rise3();
        chk("s3_bcd2", bcd, 16'h9999);
        chk("s3_wrap2", wrap, 1'b1);
        tail(3);

        sclk = 1'b1;
        step(2);
        clear = 1'b1;
        load = 1'b1;
        load_val = 16'h1234;
        step();
        clear = 1'b0;
        load = 1'b0;
        chk("s4_tick", tick, 1'b1);
        chk("s4_bcd", bcd, 16'h0000);
        chk("s4_wrap", wrap, 1'b0);
        tail(3);
        load_val = 16'h00a5;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("s4_sat", bcd, 16'h0095);
        chk("s4_lerr", load_err, 1'b1);
        step();
        chk("s4_lerr_drop", load_err, 1'b0);

        sclk = 1'b1;
        reset = 1'b0;
        up_dn = 1'b1;
        step();
        chk("s5_rst_bcd", bcd, 16'h0000);
        reset = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("s5_run", running, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("s5_no_tick", tick, 1'b0);
        end
        chk("s5_bcd", bcd, 16'h0000);
        sclk = 1'b0;
        step(10);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("s5_stopped", running, 1'b0);
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("s5_both", running, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("s5_rerun", running, 1'b1);
        sclk = 1'b1;
        step(2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("s5_stop_tick", tick, 1'b1);
        chk("s5_stop_bcd", bcd, 16'h0001);
        chk("s5_stop_run", running, 1'b0);
        tail(3);
        rise3();
        chk("s5_idle_tick", tick, 1'b1);
        chk("s5_idle_bcd", bcd, 16'h0001);
        tail(3);

        clear = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sclk = 1'b1;
            step(10);
            sclk = 1'b0;
            step(10);
        end
        chk("s6_bcd_e", bcd_e, 16'h0010);
        chk("s6_bcd", bcd, 16'h0005);
        sclk = 1'b1;
        step(4);
        #2;
        reset = 1'b0;
        #1;
        chk("s6_rst_bcd_e", bcd_e, 16'h0000);
        chk("s6_rst_run_e", running_e, 1'b0);
        chk("s6_rst_bcd", bcd, 16'h0000);
        chk("s6_rst_run", running, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sclk_bcd_counter.md
Name: sclk_bcd_counter

Overview:
Downstream consumer of the divided slow clock (sclk) produced by the clock divider. It synchronises sclk into the fast clk domain and detects its edges; sclk is never used as a clock. Each detected edge advances a DIGITS-wide packed-BCD up/down counter, gated by a start/stop state machine. The BCD value feeds display and readout logic.

Parameters:
DIGITS, 4, number of BCD digits; counter width is 4*DIGITS bits.
SYNC_STAGES, 2, synchroniser flops on sclk; legal values are 2 or more.
EDGE_SEL, 0, 0 counts sclk rising edges only; 1 counts both edges.
AUTOSTOP, 0, 1 forces the state machine to STOPPED on a wrap.

Ports:
clk  in  1  system clock; all logic is on posedge.
reset  in  1  asynchronous, active-low.
sclk  in  1  slow clock from the divider, asynchronous to the logic.
start  in  1  pulse; STOPPED to RUNNING.
stop  in  1  pulse; RUNNING to STOPPED.
up_dn  in  1  1 counts up, 0 counts down; sampled on each tick.
clear  in  1  synchronous; counter goes to zero.
load  in  1  synchronous; counter takes load_val.
load_val  in  4*DIGITS  packed BCD, digit 0 in the LSBs.
bcd  out  4*DIGITS  registered counter value.
tick  out  1  registered; one-cycle pulse per detected sclk edge.
wrap  out  1  registered; one-cycle pulse on roll-over or roll-under.
load_err  out  1  registered; one-cycle pulse when load_val held a digit greater than 9.
running  out  1  high while in RUNNING.

Behaviour:
- Reset (reset=0) is asynchronous and immediate:
  - bcd=0, tick=0, wrap=0, load_err=0, running=0, state=STOPPED.
  - Synchroniser chain, edge-history flop and prime counter all clear to 0.
- Synchroniser: sclk passes through SYNC_STAGES flops, then one history flop.
- Edge detect (internal, combinational):
  - EDGE_SEL=0: edge = s & ~h.
  - EDGE_SEL=1: edge = s ^ h.
- Prime window: edge is suppressed for the first SYNC_STAGES+1 clk edges after reset deasserts. sclk held high across reset release therefore produces no tick.
- Latency: if sclk rises with setup met before clk edge k, tick is high during the cycle after edge k+SYNC_STAGES. It is high for exactly one cycle.
- tick pulses on every detected edge, regardless of state.
- State machine, two states, registered:
  - STOPPED: start=1 and stop=0 moves to RUNNING.
  - RUNNING: stop=1 moves to STOPPED.
  - start and stop together: stop wins; next state is STOPPED.
  - AUTOSTOP=1: a wrap moves to STOPPED on the same edge.
  - running is high when state=RUNNING.
- Counter update on each clk edge, priority order:
  1. clear: bcd goes to 0. Allowed in any state. Never raises wrap.
  2. load: each digit takes load_val's digit; any digit greater than 9 saturates to 9 and load_err pulses. Allowed in any state.
  3. Count: when edge=1 and the current state is RUNNING. A tick in the same cycle as stop still counts.
- Counter update happens on the same clk edge that raises tick.
- Count up:
  - Digit 0 increments; a digit at 9 becomes 0 and carries to the next digit.
  - All digits at 9 become all 0, and wrap pulses.
- Count down:
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All digits at 0 become all 9, and wrap pulses.
- Arithmetic is per-digit 4-bit. No binary adder across the full width. A non-BCD value can never be stored.
- wrap and load_err are registered pulses, aligned with the bcd update that causes them.
- Reset asserted mid-count forces all outputs to reset values without waiting for clk. Counting resumes only after a new start.

Decomposition:
- Shared package:
  - State enum {STOPPED, RUNNING}.
  - BCD_W = 4.
  - BCD_MAX = 4'd9.
  - Per-digit increment/decrement function returning {carry, digit}.
- One sub-module, sclk_edge_sync, covers the synchroniser, history flop, prime counter and edge output. It takes parameters SYNC_STAGES and EDGE_SEL.
- The top level holds the state machine, the digit chain and the output registers.

Test Plan:
Defaults for all scenarios are DIGITS=4 and SYNC_STAGES=2. Scenarios 1–6 use EDGE_SEL=0 unless stated.
1. Release reset, pulse start, toggle sclk with a 20-clk period for 12 rising edges -> 12 one-cycle tick pulses, each 3 clk edges after its sclk rise; bcd=16'h0012; wrap never asserted.
2. load 16'h9998, up_dn=1, RUNNING, 2 rising edges -> bcd goes 16'h9999 then 16'h0000; wrap pulses once, on the second update. With AUTOSTOP=1, running drops on that same edge.
3. load 16'h0100, up_dn=0, 1 edge -> 16'h0099. Then load 16'h0000, 1 edge -> 16'h9999 with a wrap pulse.
4. clear, load 16'h1234 and an edge all in one cycle -> bcd=16'h0000 and no wrap. Then load 16'h00A5 -> bcd=16'h0095 and load_err pulses for one cycle.
5. sclk held high across reset release, then start -> no tick and bcd stays 0. Pulse start and stop in the same cycle -> running=0. An edge in the cycle stop is asserted from RUNNING -> still counts, by exactly 1.
6. EDGE_SEL=1, 5 full sclk periods -> 10 ticks and bcd=16'h0010. Assert reset mid-period -> bcd=0 and running=0 before the next clk edge.
